// File: rtl/sprite_attr_loader_pkg.sv
// Shared video package: loader FSM states, per-sprite step encoding and slot count.
// Also used by the sprite datapath that consumes the load strobes.
package sprite_attr_loader_pkg;

    localparam int NUM_SPRITES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA,
        ST_DONE
    } state_t;

    // Each sprite is loaded in eight steps; steps 4..7 are the palette bytes.
    localparam logic [2:0] STEP_NUM_FLIP = 3'd0;
    localparam logic [2:0] STEP_PAL_IDX  = 3'd1;
    localparam logic [2:0] STEP_X        = 3'd2;
    localparam logic [2:0] STEP_Y        = 3'd3;
    localparam logic [2:0] STEP_PAL_LAST = 3'd7;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational sprite-RAM address for a given sprite slot, load step and palette index.
module sprite_addr_gen
    import sprite_attr_loader_pkg::*;
#(
    parameter logic [15:0] ATTR_BASE = 16'h4FF0,
    parameter logic [15:0] POS_BASE  = 16'h5060,
    parameter logic [15:0] PAL_BASE  = 16'h8000
) (
    input  logic [2:0]  i_sprite,
    input  logic [2:0]  i_step,
    input  logic [7:0]  i_idx,
    output logic [15:0] o_addr
);

    logic [15:0] w_pair_off;

    assign w_pair_off = {12'd0, i_sprite, 1'b0};

    // All sums are 16-bit and wrap modulo 2^16.
    always_comb begin
        o_addr = PAL_BASE + {8'd0, i_idx[5:0], i_step[1:0]};
        case (i_step)
            STEP_NUM_FLIP: o_addr = ATTR_BASE + w_pair_off;
            STEP_PAL_IDX:  o_addr = ATTR_BASE + w_pair_off + 16'd1;
            STEP_X:        o_addr = POS_BASE + w_pair_off;
            STEP_Y:        o_addr = POS_BASE + w_pair_off + 16'd1;
            default:       ;
        endcase
    end

endmodule

// File: rtl/sprite_attr_loader.sv
// Loads per-sprite attribute, position and palette bytes from sprite RAM once per
// vblank, emitting one-hot load strobes into the sprite register file.
module sprite_attr_loader #(
    parameter int          NUM_SPRITES = sprite_attr_loader_pkg::NUM_SPRITES,
    parameter logic [15:0] ATTR_BASE   = 16'h4FF0,
    parameter logic [15:0] POS_BASE    = 16'h5060,
    parameter logic [15:0] PAL_BASE    = 16'h8000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblank,
    input  logic                   mem_gnt,
    input  logic [7:0]             sprite_RAM_din,
    output logic                   rd_en,
    output logic [15:0]            sprite_RAM_addr,
    output logic [7:0]             fsm_dout,
    output logic [31:0]            palette_out,
    output logic [NUM_SPRITES-1:0] ld_x,
    output logic [NUM_SPRITES-1:0] ld_y,
    output logic [NUM_SPRITES-1:0] ld_num_flips,
    output logic [NUM_SPRITES-1:0] ld_palette,
    output logic                   busy
);
    import sprite_attr_loader_pkg::*;

    state_t      r_state;
    logic [2:0]  r_step;
    logic [2:0]  r_sprite;
    logic [7:0]  r_idx;
    logic        r_vblank_d;
    logic        r_edge_ok;

    logic        w_start;
    logic        w_last_sprite;
    logic [2:0]  w_nxt_step;
    logic [2:0]  w_nxt_sprite;
    logic [15:0] w_addr;

    // r_edge_ok masks the first post-reset cycle so a vblank already high at
    // release is not mistaken for a rising edge.
    assign w_start       = r_edge_ok && vblank && !r_vblank_d;
    assign w_last_sprite = (r_sprite == 3'(NUM_SPRITES - 1));

    always_comb begin
        w_nxt_step   = 3'd0;
        w_nxt_sprite = 3'd0;
        if (r_state != ST_IDLE) begin
            w_nxt_step   = r_step + 3'd1;
            w_nxt_sprite = (r_step == STEP_PAL_LAST) ? r_sprite + 3'd1 : r_sprite;
        end
    end

    sprite_addr_gen #(
        .ATTR_BASE (ATTR_BASE),
        .POS_BASE  (POS_BASE),
        .PAL_BASE  (PAL_BASE)
    ) u_addr_gen (
        .i_sprite (w_nxt_sprite),
        .i_step   (w_nxt_step),
        .i_idx    (r_idx),
        .o_addr   (w_addr)
    );

    // NOTE: all state and outputs use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_step          <= 3'd0;
            r_sprite        <= 3'd0;
            r_idx           <= 8'd0;
            r_vblank_d      <= 1'b0;
            r_edge_ok       <= 1'b0;
            rd_en           <= 1'b0;
            sprite_RAM_addr <= 16'd0;
            fsm_dout        <= 8'd0;
            palette_out     <= 32'd0;
            ld_x            <= '0;
            ld_y            <= '0;
            ld_num_flips    <= '0;
            ld_palette      <= '0;
            busy            <= 1'b0;
        end else begin
            r_vblank_d   <= vblank;
            r_edge_ok    <= 1'b1;
            ld_x         <= '0;
            ld_y         <= '0;
            ld_num_flips <= '0;
            ld_palette   <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state         <= ST_ISSUE;
                        r_step          <= 3'd0;
                        r_sprite        <= 3'd0;
                        rd_en           <= 1'b1;
                        sprite_RAM_addr <= w_addr;
                        busy            <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!vblank) begin
                        r_state <= ST_IDLE;
                        rd_en   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (mem_gnt) begin
                        r_state <= ST_DATA;
                        rd_en   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (!vblank) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (r_step[2]) begin
                            palette_out[{~r_step[1:0], 3'b000} +: 8] <= sprite_RAM_din;
                        end else begin
                            fsm_dout <= sprite_RAM_din;
                        end
                        if (r_step == STEP_PAL_IDX) begin
                            r_idx <= sprite_RAM_din;
                        end

                        case (r_step)
                            STEP_NUM_FLIP: ld_num_flips[r_sprite] <= 1'b1;
                            STEP_X:        ld_x[r_sprite]         <= 1'b1;
                            STEP_Y:        ld_y[r_sprite]         <= 1'b1;
                            STEP_PAL_LAST: ld_palette[r_sprite]   <= 1'b1;
                            default:       ;
                        endcase

                        r_step <= w_nxt_step;
                        if (r_step == STEP_PAL_LAST && w_last_sprite) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                        end else begin
                            r_state         <= ST_ISSUE;
                            r_sprite        <= w_nxt_sprite;
                            rd_en           <= 1'b1;
                            sprite_RAM_addr <= w_addr;
                        end
                    end
                end
                ST_DONE: begin
                    if (!vblank) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    rd_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_attr_loader.sv
// Scoreboard bench for sprite_attr_loader: expected grants and strobes are queued by
// the stimulus and consumed by negedge monitors against a behavioural sprite RAM.
module tb_sprite_attr_loader;

    localparam int          NS        = 8;
    localparam logic [15:0] ATTR_BASE = 16'h4FF0;
    localparam logic [15:0] POS_BASE  = 16'h5060;
    localparam logic [15:0] PAL_BASE  = 16'h8000;

    logic          clk = 1'b0;
    logic          rst;
    logic          vblank;
    logic          mem_gnt;
    logic [7:0]    sprite_RAM_din;
    logic          rd_en;
    logic [15:0]   sprite_RAM_addr;
    logic [7:0]    fsm_dout;
    logic [31:0]   palette_out;
    logic [NS-1:0] ld_x, ld_y, ld_num_flips, ld_palette;
    logic          busy;

    sprite_attr_loader #(
        .NUM_SPRITES (NS),
        .ATTR_BASE   (ATTR_BASE),
        .POS_BASE    (POS_BASE),
        .PAL_BASE    (PAL_BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vblank          (vblank),
        .mem_gnt         (mem_gnt),
        .sprite_RAM_din  (sprite_RAM_din),
        .rd_en           (rd_en),
        .sprite_RAM_addr (sprite_RAM_addr),
        .fsm_dout        (fsm_dout),
        .palette_out     (palette_out),
        .ld_x            (ld_x),
        .ld_y            (ld_y),
        .ld_num_flips    (ld_num_flips),
        .ld_palette      (ld_palette),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 num/flip, 1 x, 2 y, 3 palette
        int          slot;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] addr_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic sb_en;

    logic [7:0]  mem [0:65535];
    logic [7:0]  attr_v [NS];
    logic [7:0]  idx_v  [NS];
    logic [7:0]  x_v    [NS];
    logic [7:0]  y_v    [NS];
    logic [31:0] pal_v  [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sprite RAM: read data appears in the cycle after the grant cycle.
    always @(posedge clk) begin
        if (rd_en && mem_gnt) sprite_RAM_din <= mem[sprite_RAM_addr];
    end

    int cyc = 0;
    int t_rise = 0, t_fall = 0, n_rise = 0;
    logic busy_q = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (busy && !busy_q) begin t_rise = cyc; n_rise++; end
        if (!busy && busy_q) t_fall = cyc;
        busy_q = busy;
    end

    // Monitor: grants pop the address queue, strobes pop the event queue.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            logic [4*NS-1:0] all_s;
            int hot, kind, slot;
            all_s = {ld_palette, ld_y, ld_x, ld_num_flips};
            hot = $countones(all_s);
            kind = 0;
            slot = 0;
            if (hot > 0) begin
                check("strobe_onehot", 32'(hot), 32'd1);
                for (int k = 0; k < 4 * NS; k++) begin
                    if (all_s[k]) begin kind = k / NS; slot = k % NS; end
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(kind * 16 + slot), 32'hFFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("strobe_kind_slot", 32'(kind * 16 + slot), 32'(e.kind * 16 + e.slot));
                    check("strobe_data", (kind == 3) ? palette_out : {24'd0, fsm_dout}, e.data);
                end
            end
            if (rd_en && mem_gnt) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_grant", {16'd0, sprite_RAM_addr}, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] ea;
                    ea = addr_q.pop_front();
                    check("grant_addr", {16'd0, sprite_RAM_addr}, {16'd0, ea});
                end
            end
        end
    end

    task automatic load_mem();
        for (int i = 0; i < NS; i++) begin
            mem[ATTR_BASE + 16'(2 * i)]     = attr_v[i];
            mem[ATTR_BASE + 16'(2 * i + 1)] = idx_v[i];
            mem[POS_BASE + 16'(2 * i)]      = x_v[i];
            mem[POS_BASE + 16'(2 * i + 1)]  = y_v[i];
            for (int l = 0; l < 4; l++) begin
                mem[PAL_BASE + {8'd0, idx_v[i][5:0], 2'(l)}] = pal_v[i][31 - 8 * l -: 8];
            end
        end
    endtask

    task automatic push_sprite(input int i, input int last_step);
        logic [15:0] a;
        for (int s = 0; s <= last_step; s++) begin
            case (s)
                0:       a = ATTR_BASE + 16'(2 * i);
                1:       a = ATTR_BASE + 16'(2 * i + 1);
                2:       a = POS_BASE + 16'(2 * i);
                3:       a = POS_BASE + 16'(2 * i + 1);
                default: a = PAL_BASE + {8'd0, idx_v[i][5:0], 2'(s - 4)};
            endcase
            addr_q.push_back(a);
            if (s == 0) exp_q.push_back('{0, i, {24'd0, attr_v[i]}});
            if (s == 2) exp_q.push_back('{1, i, {24'd0, x_v[i]}});
            if (s == 3) exp_q.push_back('{2, i, {24'd0, y_v[i]}});
            if (s == 7) exp_q.push_back('{3, i, pal_v[i]});
        end
    endtask

    task automatic push_pass();
        for (int i = 0; i < NS; i++) push_sprite(i, 7);
    endtask

    task automatic wait_busy(input logic val, input int max_cyc, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy !== val && n < max_cyc);
        check(name, {31'd0, busy}, {31'd0, val});
        #1;
    endtask

    task automatic wait_addr(input logic [15:0] target, input int max_cyc, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(rd_en === 1'b1 && sprite_RAM_addr === target) && n < max_cyc);
        check(name, {16'd0, sprite_RAM_addr}, {16'd0, target});
    endtask

    task automatic check_queues_empty(input string name);
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_addr_left"}, 32'(addr_q.size()), 32'd0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({name, "_addr"}, {16'd0, sprite_RAM_addr}, 32'd0);
        check({name, "_dout"}, {24'd0, fsm_dout}, 32'd0);
        check({name, "_pal"}, palette_out, 32'd0);
        check({name, "_strobes"}, {ld_palette, ld_y, ld_x, ld_num_flips}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int r0;
        rst     = 1'b1;
        vblank  = 1'b0;
        mem_gnt = 1'b1;
        sb_en   = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < NS; i++) begin
            attr_v[i] = 8'hA3 + 8'(i);
            idx_v[i]  = 8'h02 + 8'(i);
            x_v[i]    = 8'h3D + 8'(i);
            y_v[i]    = 8'h1F + 8'(i);
            pal_v[i]  = 32'h01020304 | {4{4'(i ^ 3), 4'h0}};
        end
        load_mem();

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Full uncontended pass; sprite 3 is A6 / idx 05 / 40 / 22 / 01020304.
        push_pass();
        vblank = 1'b1;
        wait_busy(1'b1, 10, "t1_start");
        wait_busy(1'b0, 300, "t1_done");
        check("t1_pass_len", 32'(t_fall - t_rise), 32'd128);
        check_queues_empty("t1");

        // vblank held over three frames' worth of cycles: no second pass.
        r0 = n_rise;
        repeat (3 * 140) @(posedge clk);
        #1;
        check("t1_no_repass", 32'(n_rise - r0), 32'd0);
        check("t1_done_busy", {31'd0, busy}, 32'd0);
        check("t1_done_rd_en", {31'd0, rd_en}, 32'd0);
        vblank = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Grant withheld for 5 cycles on sprite 0 step 2.
        push_pass();
        vblank = 1'b1;
        wait_addr(ATTR_BASE + 16'd1, 20, "t2_find_step1");
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("t2_rd_en_held", {31'd0, rd_en}, 32'd1);
            check("t2_addr_held", {16'd0, sprite_RAM_addr}, 32'h5060);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        wait_busy(1'b0, 400, "t2_done");
        check("t2_pass_len", 32'(t_fall - t_rise), 32'd133);
        check_queues_empty("t2");
        vblank = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // vblank drops during sprite 4 step 5: slots 0..3 and part of 4 load only.
        for (int i = 0; i < 4; i++) push_sprite(i, 7);
        push_sprite(4, 5);
        vblank = 1'b1;
        wait_addr(PAL_BASE + {8'd0, idx_v[4][5:0], 2'd1}, 200, "t3_find_s4_step5");
        @(posedge clk); #1 vblank = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t3_abort_rd_en", {31'd0, rd_en}, 32'd0);
        check("t3_abort_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t3_stays_idle", {31'd0, busy}, 32'd0);
        check_queues_empty("t3");

        // Reset mid-pass with vblank held high through release.
        sb_en = 1'b0;
        vblank = 1'b1;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_all_zero("t4_reset");
        @(posedge clk); #1 rst = 1'b0;
        r0 = n_rise;
        repeat (30) @(posedge clk);
        #1;
        check("t4_no_start", 32'(n_rise - r0), 32'd0);
        check("t4_rd_en", {31'd0, rd_en}, 32'd0);
        vblank = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete();
        addr_q.delete();
        sb_en = 1'b1;

        // idx 8'hFF on sprite 6: palette reads from 80FC..80FF.
        idx_v[6] = 8'hFF;
        load_mem();
        push_pass();
        vblank = 1'b1;
        wait_busy(1'b1, 10, "t5_start");
        wait_busy(1'b0, 300, "t5_done");
        check("t5_pass_len", 32'(t_fall - t_rise), 32'd128);
        check_queues_empty("t5");
        vblank = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_attr_loader.md
SPRITE_ATTR_LOADER -- requirements
Module: sprite_attr_loader

Interface
REQ-001 Parameter NUM_SPRITES, default 8, number of sprite slots loaded per frame.
REQ-002 Parameter ATTR_BASE, default 16'h4FF0, base address of the number/flip and palette-index byte pairs.
REQ-003 Parameter POS_BASE, default 16'h5060, base address of the x/y byte pairs.
REQ-004 Parameter PAL_BASE, default 16'h8000, base address of the palette table, 4 bytes per entry.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 vblank  in  1  vertical blank from the video timing block.
REQ-008 mem_gnt  in  1  read grant from the shared sprite-RAM port arbiter.
REQ-009 sprite_RAM_din  in  8  read data, valid in the cycle after the grant cycle.
REQ-010 rd_en  out  1  read request, held until granted.
REQ-011 sprite_RAM_addr  out  16  read address, stable while rd_en is high.
REQ-012 fsm_dout  out  8  byte for the x, y or number/flip register loads.
REQ-013 palette_out  out  32  assembled palette word for the palette register loads.
REQ-014 ld_x, ld_y, ld_num_flips, ld_palette  out  NUM_SPRITES each  one-hot load strobes, one bit per sprite slot.
REQ-015 busy  out  1  high while a load pass is in progress.

Function
REQ-016 States SHALL be IDLE, ISSUE, DATA and DONE; a 3-bit step counter (0..7) and a 3-bit sprite counter (0..NUM_SPRITES-1) SHALL qualify ISSUE and DATA.
REQ-017 In IDLE, a vblank rising edge (registered previous value 0, current 1) SHALL clear both counters and enter ISSUE; no other condition starts a pass.
REQ-018 ISSUE SHALL drive rd_en=1 with the step address, stay in ISSUE while mem_gnt=0, and enter DATA on the cycle after mem_gnt=1.
REQ-019 DATA SHALL capture sprite_RAM_din into an internal byte register; rd_en SHALL be 0 in DATA.
REQ-020 Step addresses for sprite i: step 0 ATTR_BASE+2i; step 1 ATTR_BASE+2i+1; step 2 POS_BASE+2i; step 3 POS_BASE+2i+1; steps 4..7 PAL_BASE+{8'd0, idx[5:0], step[1:0]}, where idx is the byte captured at step 1; additions are 16-bit and wrap modulo 2^16.
REQ-021 The cycle after DATA for steps 0, 2 and 3 SHALL pulse ld_num_flips[i], ld_x[i] and ld_y[i] respectively for exactly one cycle, with fsm_dout equal to the captured byte.
REQ-022 The palette bytes from steps 4, 5, 6 and 7 SHALL fill palette_out[31:24], [23:16], [15:8] and [7:0] respectively.
REQ-023 The cycle after the step-7 DATA SHALL pulse ld_palette[i] for one cycle with the complete word on palette_out.
REQ-024 Step 1 SHALL produce no strobe.
REQ-025 At most one strobe bit across all four strobe buses SHALL be high in any cycle.
REQ-026 After DATA, step<7 SHALL increment the step and return to ISSUE.
REQ-027 After DATA at step 7, the step SHALL wrap to 0 and the sprite counter SHALL increment (return to ISSUE) or, if it equals NUM_SPRITES-1, the FSM SHALL enter DONE.
REQ-028 The final strobe SHALL coincide with the transition cycle out of DATA (the first ISSUE or DONE cycle).
REQ-029 DONE SHALL hold until vblank=0, then go to IDLE; only one pass runs per vblank period.
REQ-030 vblank falling while in ISSUE or DATA SHALL abort the pass to IDLE on the next edge: no further strobes, rd_en deasserted, already-loaded slots left intact.
REQ-031 busy SHALL be 1 in ISSUE and DATA, and 0 in IDLE and DONE.
REQ-032 Uncontended minimum pass length SHALL be NUM_SPRITES*16 cycles from the first ISSUE to DONE entry.

Reset
REQ-033 rst SHALL force IDLE, both counters to 0, rd_en=0, sprite_RAM_addr=0, fsm_dout=0, palette_out=0, all strobes=0, busy=0, and the vblank edge register=0.
REQ-034 If vblank is already high at reset release, no pass SHALL start until the next rising edge.

Structure
REQ-035 The state enum, the step encoding and NUM_SPRITES SHALL live in the shared video package, shared with the sprite datapath.
REQ-036 The address generator SHALL be a combinational sub-module, sprite_addr_gen, taking sprite index, step and idx, and returning the 16-bit address.

Verification
REQ-037 The bench SHALL cover these directed cases:
- Full pass, mem_gnt tied 1, RAM preloaded (sprite 3: attr 8'hA6, idx 8'h05, x 8'h40, y 8'h22, PAL 0x8014..0x8017 = 01,02,03,04) -> ld_num_flips[3] with fsm_dout 8'hA6, ld_x[3] with 8'h40, ld_y[3] with 8'h22, ld_palette[3] with 32'h01020304; DONE after exactly 128 cycles.
- mem_gnt held low for 5 cycles on sprite 0 step 2 -> rd_en and address 16'h5060 remain stable throughout; the pass completes 5 cycles late.
- vblank falls during sprite 4 step 5 -> no strobes after that point, rd_en=0, and slots 0-3 hold their loaded values.
- rst asserted mid-pass -> all outputs 0 immediately; vblank held high after release starts no pass.
- vblank held high for 3 frames without dropping -> exactly one pass runs, then DONE persists.
- idx 8'hFF -> palette addresses 16'h80FC..16'h80FF.
